// File: rtl/seg_pattern_decoder.sv
// Segment-pattern to nibble decoder: qualifies a strobed 7-bit pattern as stable,
// decodes it against the 7-segment table and hands the nibble out over valid/ready.
module seg_pattern_decoder #(
  parameter int unsigned STABLE_CYCLES = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] seg_in,
  input  logic       seg_strobe,
  output logic [3:0] data_out,
  output logic       data_valid,
  input  logic       data_ready,
  output logic       pattern_err,
  output logic       overflow
);

  typedef enum logic [1:0] {IDLE, QUALIFY, HELD} state_e;

  localparam logic [3:0] SC = 4'(STABLE_CYCLES);

  state_e     state_q, state_d;
  logic [6:0] cand_q, cand_d;
  logic [3:0] cnt_q, cnt_d;
  logic [6:0] last_q, last_d;
  logic       have_last_q, have_last_d;
  logic [3:0] data_q, data_d;
  logic       valid_q, valid_d;
  logic       err_q, err_d;
  logic       ovf_q, ovf_d;

  logic       new_cand, qual, fire;
  logic [3:0] nib;
  logic       nib_ok;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cand_q      <= '0;
      cnt_q       <= '0;
      last_q      <= '0;
      have_last_q <= 1'b0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      err_q       <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cand_q      <= cand_d;
      cnt_q       <= cnt_d;
      last_q      <= last_d;
      have_last_q <= have_last_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      err_q       <= err_d;
      ovf_q       <= ovf_d;
    end
  end

  // Filter and stability state; a saturated count at 15 never re-qualifies from HELD.
  always_comb begin
    cand_d   = cand_q;
    cnt_d    = cnt_q;
    new_cand = 1'b0;
    if (seg_strobe) begin
      if (seg_in == cand_q) begin
        cnt_d = (cnt_q == 4'hF) ? cnt_q : cnt_q + 4'd1;
      end else begin
        cand_d   = seg_in;
        cnt_d    = 4'd1;
        new_cand = 1'b1;
      end
    end

    if (cnt_d == '0)     state_d = IDLE;
    else if (cnt_d < SC) state_d = QUALIFY;
    else                 state_d = HELD;

    qual        = seg_strobe && (cnt_d == SC) && (new_cand || state_q != HELD);
    fire        = qual && !(have_last_q && cand_d == last_q);
    last_d      = fire ? cand_d : last_q;
    have_last_d = have_last_q | fire;
  end

  always_comb begin
    nib_ok = 1'b1;
    case (cand_d)
      7'b1111110: nib = 4'h0;
      7'b1000000: nib = 4'h1;
      7'b1000001: nib = 4'h2;
      7'b1001001: nib = 4'h3;
      7'b0100011: nib = 4'h4;
      7'b0011101: nib = 4'h5;
      7'b0101001: nib = 4'h6;
      7'b0010011: nib = 4'h7;
      7'b0110110: nib = 4'h8;
      7'b0110111: nib = 4'h9;
      7'b1110111: nib = 4'hA;
      7'b0011111: nib = 4'hB;
      7'b1001110: nib = 4'hC;
      7'b0111101: nib = 4'hD;
      7'b1101111: nib = 4'hE;
      7'b1000111: nib = 4'hF;
      default: begin
        nib    = '0;
        nib_ok = 1'b0;
      end
    endcase
  end

  // Output register: a same-cycle acceptance frees the slot for a new decode.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q & ~data_ready;
    err_d   = fire & ~nib_ok;
    ovf_d   = 1'b0;
    if (fire && nib_ok) begin
      if (!valid_q || data_ready) begin
        data_d  = nib;
        valid_d = 1'b1;
      end else begin
        ovf_d = 1'b1;
      end
    end
  end

  assign data_out    = data_q;
  assign data_valid  = valid_q;
  assign pattern_err = err_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_seg_pattern_decoder.sv
// Bench for seg_pattern_decoder: three instances (STABLE_CYCLES 1, 3, 15) share stimulus
// and are compared every cycle against a sample-history reference model.
module tb_seg_pattern_decoder;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] seg;
  logic       strobe;
  logic       ready;

  logic [3:0] dout [3];
  logic       dv   [3];
  logic       perr [3];
  logic       ovf  [3];

  always #5 clk = ~clk;

  seg_pattern_decoder #(.STABLE_CYCLES(1)) u_sc1 (
    .clk(clk), .rst(rst), .seg_in(seg), .seg_strobe(strobe),
    .data_out(dout[0]), .data_valid(dv[0]), .data_ready(ready),
    .pattern_err(perr[0]), .overflow(ovf[0]));

  seg_pattern_decoder #(.STABLE_CYCLES(3)) u_sc3 (
    .clk(clk), .rst(rst), .seg_in(seg), .seg_strobe(strobe),
    .data_out(dout[1]), .data_valid(dv[1]), .data_ready(ready),
    .pattern_err(perr[1]), .overflow(ovf[1]));

  seg_pattern_decoder #(.STABLE_CYCLES(15)) u_sc15 (
    .clk(clk), .rst(rst), .seg_in(seg), .seg_strobe(strobe),
    .data_out(dout[2]), .data_valid(dv[2]), .data_ready(ready),
    .pattern_err(perr[2]), .overflow(ovf[2]));

  int n_vec = 0;
  int n_err = 0;

  logic [6:0] tab [16];
  int         scv [3];

  // Reference model state: newest strobed sample at index 0.
  logic [6:0] hist  [3][16];
  int         hlen  [3];
  logic [6:0] mlast [3];
  bit         mhave [3];
  bit         ev    [3];
  logic [3:0] ed    [3];
  bit         ee    [3];
  bit         eo    [3];

  typedef struct {
    logic       r;
    logic [6:0] s;
    logic       st;
    logic       rdy;
    logic       v;
    logic [3:0] d;
    logic       e;
    logic       o;
  } vec_t;

  vec_t tbl [22];

  function automatic vec_t mk(logic r, logic [6:0] s, logic st, logic rdy,
                              logic v, logic [3:0] d, logic e, logic o);
    vec_t x;
    x.r = r; x.s = s; x.st = st; x.rdy = rdy; x.v = v; x.d = d; x.e = e; x.o = o;
    return x;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_step(input int k, input logic r, input logic [6:0] s,
                            input logic st, input logic rdy);
    int  run;
    bit  found;
    logic [3:0] n;
    if (r) begin
      hlen[k] = 0; mhave[k] = 0; ev[k] = 0; ed[k] = '0; ee[k] = 0; eo[k] = 0;
      return;
    end
    ee[k] = 0;
    eo[k] = 0;
    if (ev[k] && rdy) ev[k] = 0;
    if (st) begin
      for (int j = 15; j > 0; j--) hist[k][j] = hist[k][j-1];
      hist[k][0] = s;
      if (hlen[k] < 16) hlen[k]++;
      run = 0;
      for (int j = 0; j < hlen[k]; j++) begin
        if (hist[k][j] != s) break;
        run++;
      end
      if (run == scv[k] && !(mhave[k] && mlast[k] == s)) begin
        mlast[k] = s;
        mhave[k] = 1;
        found = 0;
        n = '0;
        for (int i = 0; i < 16; i++)
          if (tab[i] == s) begin found = 1; n = 4'(i); end
        if (!found)       ee[k] = 1;
        else if (!ev[k]) begin ev[k] = 1; ed[k] = n; end
        else              eo[k] = 1;
      end
    end
  endtask

  task automatic cycle(input logic r, input logic [6:0] s, input logic st, input logic rdy);
    rst = r; seg = s; strobe = st; ready = rdy;
    @(posedge clk);
    for (int k = 0; k < 3; k++) model_step(k, r, s, st, rdy);
    #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("model sc%0d valid", scv[k]), int'(dv[k]), int'(ev[k]));
      chk($sformatf("model sc%0d data", scv[k]), int'(dout[k]), int'(ed[k]));
      chk($sformatf("model sc%0d err", scv[k]), int'(perr[k]), int'(ee[k]));
      chk($sformatf("model sc%0d ovf", scv[k]), int'(ovf[k]), int'(eo[k]));
    end
  endtask

  task automatic expect_k(input string nm, input int k, input logic v, input logic [3:0] d,
                          input logic e, input logic o);
    chk({nm, " valid"}, int'(dv[k]), int'(v));
    chk({nm, " data"}, int'(dout[k]), int'(d));
    chk({nm, " err"}, int'(perr[k]), int'(e));
    chk({nm, " ovf"}, int'(ovf[k]), int'(o));
  endtask

  localparam logic [6:0] P0 = 7'b1111110;
  localparam logic [6:0] P1 = 7'b1000000;
  localparam logic [6:0] P3 = 7'b1001001;
  localparam logic [6:0] P4 = 7'b0100011;
  localparam logic [6:0] PA = 7'b1110111;
  localparam logic [6:0] PF = 7'b1000111;
  localparam logic [6:0] PZ = 7'b0000000;

  initial begin
    logic [6:0] rseg;
    int         runleft;
    int         pick;

    tab = '{7'b1111110, 7'b1000000, 7'b1000001, 7'b1001001, 7'b0100011, 7'b0011101,
            7'b0101001, 7'b0010011, 7'b0110110, 7'b0110111, 7'b1110111, 7'b0011111,
            7'b1001110, 7'b0111101, 7'b1101111, 7'b1000111};
    scv = '{1, 3, 15};
    rst = 1'b1; seg = '0; strobe = 1'b0; ready = 1'b0;

    // Directed table for STABLE_CYCLES=3: reset, basic emit, invalid pattern, overflow.
    tbl[0]  = mk(1, PZ, 0, 0, 0, 4'h0, 0, 0);
    tbl[1]  = mk(1, PZ, 0, 0, 0, 4'h0, 0, 0);
    tbl[2]  = mk(0, PZ, 0, 1, 0, 4'h0, 0, 0);
    tbl[3]  = mk(0, P4, 1, 1, 0, 4'h0, 0, 0);
    tbl[4]  = mk(0, P4, 1, 1, 0, 4'h0, 0, 0);
    tbl[5]  = mk(0, P4, 1, 1, 1, 4'h4, 0, 0);
    tbl[6]  = mk(0, P4, 0, 1, 0, 4'h4, 0, 0);
    tbl[7]  = mk(0, P4, 1, 1, 0, 4'h4, 0, 0);
    tbl[8]  = mk(0, P4, 1, 1, 0, 4'h4, 0, 0);
    tbl[9]  = mk(0, PZ, 1, 1, 0, 4'h4, 0, 0);
    tbl[10] = mk(0, PZ, 1, 1, 0, 4'h4, 0, 0);
    tbl[11] = mk(0, PZ, 1, 1, 0, 4'h4, 1, 0);
    tbl[12] = mk(0, PZ, 0, 1, 0, 4'h4, 0, 0);
    tbl[13] = mk(0, PA, 1, 0, 0, 4'h4, 0, 0);
    tbl[14] = mk(0, PA, 1, 0, 0, 4'h4, 0, 0);
    tbl[15] = mk(0, PA, 1, 0, 1, 4'hA, 0, 0);
    tbl[16] = mk(0, PF, 1, 0, 1, 4'hA, 0, 0);
    tbl[17] = mk(0, PF, 1, 0, 1, 4'hA, 0, 0);
    tbl[18] = mk(0, PF, 1, 0, 1, 4'hA, 0, 1);
    tbl[19] = mk(0, PF, 0, 0, 1, 4'hA, 0, 0);
    tbl[20] = mk(0, PF, 0, 1, 0, 4'hA, 0, 0);
    tbl[21] = mk(0, PF, 0, 1, 0, 4'hA, 0, 0);

    for (int i = 0; i < 22; i++) begin
      cycle(tbl[i].r, tbl[i].s, tbl[i].st, tbl[i].rdy);
      expect_k($sformatf("tbl[%0d]", i), 1, tbl[i].v, tbl[i].d, tbl[i].e, tbl[i].o);
    end

    // Glitch in the middle of a run restarts qualification without an error.
    cycle(0, P3, 1, 1); expect_k("glitch s1", 1, 0, 4'hA, 0, 0);
    cycle(0, P3, 1, 1); expect_k("glitch s2", 1, 0, 4'hA, 0, 0);
    cycle(0, 7'b0000001, 1, 1); expect_k("glitch s3", 1, 0, 4'hA, 0, 0);
    cycle(0, P3, 1, 1); expect_k("glitch s4", 1, 0, 4'hA, 0, 0);
    cycle(0, P3, 1, 1); expect_k("glitch s5", 1, 0, 4'hA, 0, 0);
    cycle(0, P3, 1, 1); expect_k("glitch s6", 1, 1, 4'h3, 0, 0);
    cycle(0, P3, 0, 1); expect_k("glitch ack", 1, 0, 4'h3, 0, 0);

    // Reset part-way through qualification.
    cycle(0, P0, 1, 1); expect_k("midrst s1", 1, 0, 4'h3, 0, 0);
    cycle(0, P0, 1, 1); expect_k("midrst s2", 1, 0, 4'h3, 0, 0);
    cycle(1, P0, 0, 1); expect_k("midrst rst", 1, 0, 4'h0, 0, 0);
    cycle(0, P0, 1, 1); expect_k("midrst r1", 1, 0, 4'h0, 0, 0);
    cycle(0, P0, 1, 1); expect_k("midrst r2", 1, 0, 4'h0, 0, 0);
    cycle(0, P0, 1, 1); expect_k("midrst r3", 1, 1, 4'h0, 0, 0);
    cycle(0, P0, 0, 1); expect_k("midrst ack", 1, 0, 4'h0, 0, 0);

    // The same stable pattern is emitted again after a reset.
    for (int i = 0; i < 3; i++) cycle(0, P1, 1, 1);
    expect_k("repeat pre", 1, 1, 4'h1, 0, 0);
    cycle(1, P1, 0, 1); expect_k("repeat rst", 1, 0, 4'h0, 0, 0);
    for (int i = 0; i < 3; i++) cycle(0, P1, 1, 1);
    expect_k("repeat post", 1, 1, 4'h1, 0, 0);
    cycle(0, P1, 0, 1);

    // Sweep every table entry on the 1- and 15-sample instances.
    for (int i = 0; i < 16; i++) begin
      for (int c = 1; c <= 15; c++) begin
        cycle(0, tab[i], 1, 1);
        if (c == 1)  expect_k($sformatf("sweep sc1 %0d", i), 0, 1, 4'(i), 0, 0);
        if (c == 15) expect_k($sformatf("sweep sc15 %0d", i), 2, 1, 4'(i), 0, 0);
      end
    end

    // Randomized runs of patterns checked against the reference model.
    runleft = 0;
    rseg = '0;
    for (int n = 0; n < 3000; n++) begin
      if (runleft == 0) begin
        pick = int'($urandom_range(0, 5));
        case (pick)
          0: rseg = tab[2];
          1: rseg = tab[7];
          2: rseg = tab[12];
          3: rseg = tab[$urandom_range(0, 15)];
          4: rseg = 7'b0000000;
          default: rseg = 7'($urandom);
        endcase
        runleft = int'($urandom_range(1, 20));
      end
      strobe = ($urandom_range(0, 9) < 7);
      if (strobe) runleft--;
      cycle(($urandom_range(0, 199) == 0), rseg, strobe, ($urandom_range(0, 1) == 1));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
